alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL: i_clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: i_rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: i_valid  input  1  upstream (decode) offers an instruction.
REQ-004 SHALL: o_ready  output  1  block can accept an instruction this cycle.
REQ-005 SHALL: i_op  input  4  ALU operation code (ALU_DEFINES encoding), passed through unchanged.
REQ-006 SHALL: i_Ra, i_Rb  input  XLEN each  register-file operands.
REQ-007 SHALL: i_rs1, i_rs2  input  5 each  source register indices of i_Ra/i_Rb; 0 = x0 or immediate operand.
REQ-008 SHALL: i_rd  input  5  destination register index.
REQ-009 SHALL: i_flush  input  1  discard all held instructions.
REQ-010 SHALL: o_valid  output  1  instruction presented to ALU.
REQ-011 SHALL: i_ready  input  1  ALU side consumes the presented instruction.
REQ-012 SHALL: o_op  output  4; o_Ra, o_Rb  output  XLEN each; o_rd  output  5  registered instruction fields.
REQ-013 SHALL: i_fwd_en  input  1; i_fwd_rd  input  5; i_fwd_data  input  XLEN  writeback forwarding source.

Function
REQ-014 SHALL: two storage entries, OUT (drives o_*) and SKID, each with a valid bit; o_valid = OUT.valid.
REQ-015 SHALL: o_ready = !SKID.valid, a pure register decode, no combinational path from i_ready.
REQ-016 SHALL: accept occurs when i_valid && o_ready; consume occurs when o_valid && i_ready.
REQ-017 SHALL: accept with OUT empty, or with consume in the same cycle and SKID empty: incoming loads OUT; latency accept-to-o_valid is 1 cycle.
REQ-018 SHALL: accept while OUT valid and not consumed: incoming loads SKID.
REQ-019 SHALL: consume with SKID valid: SKID moves to OUT, SKID cleared; any accept that cycle is blocked (o_ready was 0).
REQ-020 SHALL: consume with SKID empty and no accept: OUT.valid cleared.
REQ-021 SHALL: order preserved; no instruction dropped or duplicated outside flush.
REQ-022 SHALL: i_flush clears OUT.valid and SKID.valid on the next edge; flush wins over simultaneous accept and consume (accepted instruction discarded).
REQ-023 SHALL: o_op/o_Ra/o_Rb/o_rd hold stable while o_valid && !i_ready (except forwarding update, REQ-026).

Reset
REQ-024 SHALL: while i_rst low: OUT.valid=0, SKID.valid=0, o_valid=0, o_ready=1, o_op=0, o_Ra=0, o_Rb=0, o_rd=0, SKID fields 0; release needs no clock alignment beyond synchronous deassert by the top level.

Configuration
REQ-025 SHALL: macro ALU_ISSUE_FWD_EN enables forwarding; ports of REQ-013 exist in both builds.
REQ-026 SHALL: with ALU_ISSUE_FWD_EN: at accept, operand n replaced by i_fwd_data when i_fwd_en && i_fwd_rd==i_rsn && i_rsn!=0; held OUT/SKID operands likewise overwritten in any cycle a matching forward arrives (rs indices stored per entry); rs==0 never forwarded.
REQ-027 SHALL: without ALU_ISSUE_FWD_EN: i_fwd_* ignored, operands captured verbatim, rs indices need not be stored.

Verification
REQ-028 SHALL: reset low mid-traffic with both entries full -> same cycle o_valid=0, o_ready=1, o_Ra=0.
REQ-029 SHALL: i_ready=1 steady, accept A(op=ADD,Ra=5,Rb=7) then B back-to-back -> o_valid 1 cycle later each, o_ready stays 1, order A,B.
REQ-030 SHALL: i_ready=0, offer A,B,C -> A in OUT, B in SKID, o_ready=0, C held by upstream; i_ready=1 one cycle -> B on o_*, o_ready=1, then C accepted.
REQ-031 SHALL: OUT and SKID full, i_flush=1 with i_valid=1 and i_ready=1 -> next cycle o_valid=0, o_ready=1, nothing delivered.
REQ-032 SHALL (FWD_EN): accept rs1=3, i_Ra=1, i_fwd_en=1, i_fwd_rd=3, i_fwd_data=0xDEAD -> o_Ra=0xDEAD; same with rs1=0 -> o_Ra=1; held entry stalled, forward rd=3 data=0xBEEF -> o_Ra=0xBEEF next cycle.
REQ-033 SHALL (no FWD_EN): same stimulus as REQ-032 -> o_Ra=1 in all cases.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue -- two-entry issue buffer between decode and the ALU.
//
// The OUT entry drives the o_* fields and the SKID entry catches one
// instruction while the ALU stalls. o_ready is a pure register decode, so
// there is no combinational path from i_ready to o_ready. Instruction order
// is preserved. i_flush discards both entries and any same-cycle accept.
//
// Optional feature: define ALU_ISSUE_FWD_EN to enable writeback forwarding.
// In that build, operands are replaced by i_fwd_data when i_fwd_rd matches
// a non-zero source index. This applies at accept and to held entries in
// any cycle. Without the macro, the i_fwd_* inputs are ignored.
//
// Ports:
//   i_clk, i_rst                 clock, asynchronous active-low reset
//   i_valid / o_ready            upstream handshake (decode side)
//   i_op, i_Ra, i_Rb             incoming opcode and operands
//   i_rs1, i_rs2, i_rd           source / destination register indices
//   i_flush                      discard all held instructions
//   o_valid / i_ready            downstream handshake (ALU side)
//   o_op, o_Ra, o_Rb, o_rd       registered instruction fields
//   i_fwd_en, i_fwd_rd,
//   i_fwd_data                   writeback forwarding source
module alu_issue #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_Ra,
  input  logic [XLEN-1:0] i_Rb,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [3:0]      o_op,
  output logic [XLEN-1:0] o_Ra,
  output logic [XLEN-1:0] o_Rb,
  output logic [4:0]      o_rd,
  input  logic            i_fwd_en,
  input  logic [4:0]      i_fwd_rd,
  input  logic [XLEN-1:0] i_fwd_data
);

  // EMPTY: no entry valid; HALF: OUT valid only; FULL: OUT and SKID valid.
  typedef enum logic [1:0] {EMPTY, HALF, FULL} occ_t;

  occ_t state, state_next;

  logic accept, consume;
  logic load_out, load_skid, move;

  logic [3:0]      out_op,  skid_op;
  logic [XLEN-1:0] out_ra,  out_rb;
  logic [XLEN-1:0] skid_ra, skid_rb;
  logic [4:0]      out_rd,  skid_rd;

  // Operand values after any forwarding for this cycle.
  logic [XLEN-1:0] in_ra, in_rb;
  logic [XLEN-1:0] hold_out_ra, hold_out_rb;
  logic [XLEN-1:0] hold_skid_ra, hold_skid_rb;

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= EMPTY;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) state_next = HALF;
        HALF: begin
          if (accept && !consume)      state_next = FULL;
          else if (!accept && consume) state_next = EMPTY;
        end
        FULL:    if (consume) state_next = HALF;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Output decode (registered state only)
  always_comb begin
    o_valid = (state != EMPTY);
    o_ready = (state != FULL);
  end

  assign accept  = i_valid && o_ready;
  assign consume = o_valid && i_ready;

  // Incoming data goes to OUT when OUT is free or is being drained this cycle.
  // Otherwise it goes to SKID. A consume while FULL promotes SKID; accept is
  // impossible in that cycle because o_ready is low.
  assign load_out  = !i_flush && accept && (state == EMPTY || consume);
  assign load_skid = !i_flush && accept && (state == HALF) && !consume;
  assign move      = !i_flush && consume && (state == FULL);

`ifdef ALU_ISSUE_FWD_EN
  logic [4:0] out_rs1, out_rs2, skid_rs1, skid_rs2;

  function automatic logic fwd_hit(input logic en, input logic [4:0] frd,
                                   input logic [4:0] rs);
    return en && (rs != '0) && (rs == frd);
  endfunction

  always_comb begin
    in_ra        = fwd_hit(i_fwd_en, i_fwd_rd, i_rs1) ? i_fwd_data : i_Ra;
    in_rb        = fwd_hit(i_fwd_en, i_fwd_rd, i_rs2) ? i_fwd_data : i_Rb;
    hold_out_ra  = (o_valid && fwd_hit(i_fwd_en, i_fwd_rd, out_rs1))
                   ? i_fwd_data : out_ra;
    hold_out_rb  = (o_valid && fwd_hit(i_fwd_en, i_fwd_rd, out_rs2))
                   ? i_fwd_data : out_rb;
    hold_skid_ra = ((state == FULL) && fwd_hit(i_fwd_en, i_fwd_rd, skid_rs1))
                   ? i_fwd_data : skid_ra;
    hold_skid_rb = ((state == FULL) && fwd_hit(i_fwd_en, i_fwd_rd, skid_rs2))
                   ? i_fwd_data : skid_rb;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_rs1  <= '0;
      out_rs2  <= '0;
      skid_rs1 <= '0;
      skid_rs2 <= '0;
    end else begin
      if (load_out) begin
        out_rs1 <= i_rs1;
        out_rs2 <= i_rs2;
      end else if (move) begin
        out_rs1 <= skid_rs1;
        out_rs2 <= skid_rs2;
      end
      if (load_skid) begin
        skid_rs1 <= i_rs1;
        skid_rs2 <= i_rs2;
      end
    end
  end
`else
  always_comb begin
    in_ra        = i_Ra;
    in_rb        = i_Rb;
    hold_out_ra  = out_ra;
    hold_out_rb  = out_rb;
    hold_skid_ra = skid_ra;
    hold_skid_rb = skid_rb;
  end

  logic unused_fwd;
  assign unused_fwd = ^{i_fwd_en, i_fwd_rd, i_fwd_data, i_rs1, i_rs2};
`endif

  // Entry datapath. The hold paths carry forwarded operands, and the SKID to
  // OUT move uses the forwarded SKID operands so a same-cycle writeback is
  // not lost.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      out_op  <= '0;
      out_ra  <= '0;
      out_rb  <= '0;
      out_rd  <= '0;
      skid_op <= '0;
      skid_ra <= '0;
      skid_rb <= '0;
      skid_rd <= '0;
    end else begin
      if (load_out) begin
        out_op <= i_op;
        out_ra <= in_ra;
        out_rb <= in_rb;
        out_rd <= i_rd;
      end else if (move) begin
        out_op <= skid_op;
        out_ra <= hold_skid_ra;
        out_rb <= hold_skid_rb;
        out_rd <= skid_rd;
      end else begin
        out_ra <= hold_out_ra;
        out_rb <= hold_out_rb;
      end
      if (load_skid) begin
        skid_op <= i_op;
        skid_ra <= in_ra;
        skid_rb <= in_rb;
        skid_rd <= i_rd;
      end else begin
        skid_ra <= hold_skid_ra;
        skid_rb <= hold_skid_rb;
      end
    end
  end

  assign o_op = out_op;
  assign o_Ra = out_ra;
  assign o_Rb = out_rb;
  assign o_rd = out_rd;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue -- bench for alu_issue. It uses a directed vector table,
// hand-written forwarding and reset sequences, and random traffic checked
// against a queue-based reference model.
module tb_alu_issue;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_ready = 1'b0, i_flush = 1'b0;
  logic [3:0]  i_op = '0;
  logic [31:0] i_Ra = '0, i_Rb = '0, i_fwd_data = '0;
  logic [4:0]  i_rs1 = '0, i_rs2 = '0, i_rd = '0, i_fwd_rd = '0;
  logic        i_fwd_en = 1'b0;
  logic        o_ready, o_valid;
  logic [3:0]  o_op;
  logic [31:0] o_Ra, o_Rb;
  logic [4:0]  o_rd;

  alu_issue #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_Ra(i_Ra), .i_Rb(i_Rb), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_rd(i_rd), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_op(o_op), .o_Ra(o_Ra), .o_Rb(o_Rb), .o_rd(o_rd),
    .i_fwd_en(i_fwd_en), .i_fwd_rd(i_fwd_rd), .i_fwd_data(i_fwd_data)
  );

  always #5 i_clk = ~i_clk;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic drive(input logic v, input logic rdy, input logic fl,
                       input logic [3:0] op, input logic [31:0] ra,
                       input logic [31:0] rb, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd,
                       input logic fen, input logic [4:0] frd,
                       input logic [31:0] fdata);
    i_valid = v; i_ready = rdy; i_flush = fl;
    i_op = op; i_Ra = ra; i_Rb = rb; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_fwd_en = fen; i_fwd_rd = frd; i_fwd_data = fdata;
  endtask

  // Directed vectors. Instruction tag t carries op=t[3:0], Ra=0x100+t,
  // Rb=0x200+t and rd=t[4:0]. Expected values are the outputs after the edge.
  typedef struct {
    logic v, rdy, fl;
    int   tag;
    logic ev, erdy;
    int   etag;
  } vec_t;

  vec_t vecs[17];

  // Reference model: an in-order queue holding at most two instructions.
  typedef struct {
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic [4:0]  rs1, rs2, rd;
  } ins_t;

  ins_t q[$];

  function automatic logic [31:0] fwd_val(input logic [31:0] d,
                                          input logic [4:0] rs);
    if (FWD && i_fwd_en && rs != 5'd0 && rs == i_fwd_rd) return i_fwd_data;
    return d;
  endfunction

  task automatic model_step();
    logic acc, con;
    ins_t n;
    acc = i_valid && (q.size() < 2);
    con = (q.size() > 0) && i_ready;
    if (i_flush) begin
      q.delete();
    end else begin
      foreach (q[k]) begin
        q[k].ra = fwd_val(q[k].ra, q[k].rs1);
        q[k].rb = fwd_val(q[k].rb, q[k].rs2);
      end
      if (con) void'(q.pop_front());
      if (acc) begin
        n.op = i_op; n.rd = i_rd; n.rs1 = i_rs1; n.rs2 = i_rs2;
        n.ra = fwd_val(i_Ra, i_rs1);
        n.rb = fwd_val(i_Rb, i_rs2);
        q.push_back(n);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] t;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2,  1'b1, 1'b1, 2};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b1, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 1'b1, 3};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4,  1'b1, 1'b0, 3};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5,  1'b1, 1'b0, 3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 5,  1'b1, 1'b1, 4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 5,  1'b1, 1'b0, 4};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 0,  1'b1, 1'b1, 5};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b1, 0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 6,  1'b1, 1'b1, 6};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 7,  1'b1, 1'b0, 6};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 8,  1'b0, 1'b1, 0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 0,  1'b0, 1'b1, 0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 9,  1'b1, 1'b1, 9};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b1, 0};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 0,  1'b0, 1'b1, 0};

    // Reset state
    #1 i_rst = 1'b0;
    #2;
    check("rst_o_valid", {31'd0, o_valid}, 32'd0);
    check("rst_o_ready", {31'd0, o_ready}, 32'd1);
    check("rst_o_op",    {28'd0, o_op},    32'd0);
    check("rst_o_Ra",    o_Ra,             32'd0);
    check("rst_o_Rb",    o_Rb,             32'd0);
    check("rst_o_rd",    {27'd0, o_rd},    32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 17; i++) begin
      t = vecs[i].tag;
      drive(vecs[i].v, vecs[i].rdy, vecs[i].fl, t[3:0], 32'h100 + t,
            32'h200 + t, 5'd0, 5'd0, t[4:0], 1'b0, 5'd0, 32'd0);
      @(negedge i_clk);
      check("vec_o_valid", {31'd0, o_valid}, {31'd0, vecs[i].ev});
      check("vec_o_ready", {31'd0, o_ready}, {31'd0, vecs[i].erdy});
      if (vecs[i].ev) begin
        t = vecs[i].etag;
        check("vec_o_op", {28'd0, o_op}, {28'd0, t[3:0]});
        check("vec_o_Ra", o_Ra, 32'h100 + t);
        check("vec_o_Rb", o_Rb, 32'h200 + t);
        check("vec_o_rd", {27'd0, o_rd}, {27'd0, t[4:0]});
      end
    end

    // Forwarding sequences (in the default build the operands pass unchanged)
    drive(1, 0, 0, 4'h1, 32'd1, 32'd2, 5'd3, 5'd0, 5'd9, 1, 5'd3, 32'hDEAD);
    @(negedge i_clk);
    check("fwd_accept_valid", {31'd0, o_valid}, 32'd1);
    check("fwd_accept_Ra", o_Ra, FWD ? 32'hDEAD : 32'd1);
    drive(0, 1, 0, 4'h0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    drive(1, 0, 0, 4'h1, 32'd1, 32'd2, 5'd0, 5'd0, 5'd9, 1, 5'd0, 32'hDEAD);
    @(negedge i_clk);
    check("fwd_rs0_Ra", o_Ra, 32'd1);
    drive(0, 1, 0, 4'h0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    drive(1, 0, 0, 4'h1, 32'd1, 32'd2, 5'd3, 5'd0, 5'd9, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    check("fwd_held_pre_Ra", o_Ra, 32'd1);
    drive(0, 0, 0, 4'h0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1, 5'd3, 32'hBEEF);
    @(negedge i_clk);
    check("fwd_held_Ra", o_Ra, FWD ? 32'hBEEF : 32'd1);
    check("fwd_held_valid", {31'd0, o_valid}, 32'd1);
    drive(0, 1, 0, 4'h0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    check("fwd_drain_valid", {31'd0, o_valid}, 32'd0);

    // Asynchronous reset with both entries full
    drive(1, 0, 0, 4'h3, 32'h11, 32'h12, 5'd0, 5'd0, 5'd1, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    drive(1, 0, 0, 4'h4, 32'h21, 32'h22, 5'd0, 5'd0, 5'd2, 0, 5'd0, 32'd0);
    @(negedge i_clk);
    check("full_o_ready", {31'd0, o_ready}, 32'd0);
    drive(0, 0, 0, 4'h0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0);
    #2 i_rst = 1'b0;
    #1;
    check("midrst_o_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_o_ready", {31'd0, o_ready}, 32'd1);
    check("midrst_o_Ra", o_Ra, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b1;
    q.delete();

    // Random traffic against the queue model
    for (int c = 0; c < 300; c++) begin
      check("rnd_o_valid", {31'd0, o_valid}, {31'd0, q.size() > 0});
      check("rnd_o_ready", {31'd0, o_ready}, {31'd0, q.size() < 2});
      if (q.size() > 0) begin
        check("rnd_o_op", {28'd0, o_op}, {28'd0, q[0].op});
        check("rnd_o_Ra", o_Ra, q[0].ra);
        check("rnd_o_Rb", o_Rb, q[0].rb);
        check("rnd_o_rd", {27'd0, o_rd}, {27'd0, q[0].rd});
      end
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 4, 4'($urandom), $urandom, $urandom,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 3)), $urandom);
      model_step();
      @(negedge i_clk);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
